// File: rtl/accum_tile_sequencer.sv
// Walks output-tile coordinates for the systolic array and drives column-skewed accumulator writes.
// Optional perf counters (perf_cycles, perf_stalls) are built when ACCUM_SEQ_PERF_EN is defined.
module accum_tile_sequencer #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int MAX_K_TILES  = 8,
  localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
  localparam int AW = $clog2(NUM_ACCUM_ROWS),
  localparam int MW = $clog2(NUM_SUBMATS_M),
  localparam int NW = $clog2(NUM_SUBMATS_N),
  localparam int KW = $clog2(MAX_K_TILES),
  localparam int CW = $clog2(SYS_ARR_ROWS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MW-1:0]              num_m_m1,
  input  logic [NW-1:0]              num_n_m1,
  input  logic [KW-1:0]              num_k_m1,
  input  logic                       stall,
  output logic                       busy,
  output logic                       done,
  output logic                       issue_valid,
  output logic [CW-1:0]              sys_arr_count,
  output logic [MW-1:0]              submat_m,
  output logic [NW-1:0]              submat_n,
`ifdef ACCUM_SEQ_PERF_EN
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_stalls,
`endif
  output logic [SYS_ARR_COLS-1:0]    wr_en,
  output logic [SYS_ARR_COLS-1:0]    wr_acc,
  output logic [AW*SYS_ARR_COLS-1:0] wr_addr
);

  localparam int DW = $clog2(SYS_ARR_COLS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SYS_ARR_ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(SYS_ARR_COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg;
  logic          busy_reg, done_reg, issue_reg;
  logic [CW-1:0] cnt_reg;
  logic [KW-1:0] k_reg, nk_reg;
  logic [MW-1:0] m_reg, nm_reg;
  logic [NW-1:0] n_reg, nn_reg;
  logic [DW-1:0] drain_reg;

  logic          last_row;
  logic [AW-1:0] head_addr;
  logic          head_acc;

  assign last_row = (cnt_reg == CNT_LAST) && (k_reg == nk_reg) &&
                    (m_reg == nm_reg) && (n_reg == nn_reg);

  // The counters always show the most recently issued row; an unstalled edge moves to the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      issue_reg <= 1'b0;
      cnt_reg   <= '0;
      k_reg     <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
      nk_reg    <= '0;
      nm_reg    <= '0;
      nn_reg    <= '0;
      drain_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            issue_reg <= 1'b1;
            nm_reg    <= num_m_m1;
            nn_reg    <= num_n_m1;
            nk_reg    <= num_k_m1;
            cnt_reg   <= '0;
            k_reg     <= '0;
            m_reg     <= '0;
            n_reg     <= '0;
          end
        end
        RUN: begin
          if (stall) begin
            issue_reg <= 1'b0;
          end else if (last_row) begin
            issue_reg <= 1'b0;
            state_reg <= DRAIN;
            drain_reg <= '0;
          end else begin
            issue_reg <= 1'b1;
            if (cnt_reg != CNT_LAST) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else begin
              cnt_reg <= '0;
              if (k_reg != nk_reg) begin
                k_reg <= k_reg + 1'b1;
              end else begin
                k_reg <= '0;
                if (m_reg != nm_reg) begin
                  m_reg <= m_reg + 1'b1;
                end else begin
                  m_reg <= '0;
                  n_reg <= n_reg + 1'b1;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign issue_valid   = issue_reg;
  assign sys_arr_count = cnt_reg;
  assign submat_m      = m_reg;
  assign submat_n      = n_reg;

  assign head_addr = AW'(n_reg) * AW'(MAX_OUT_ROWS) + AW'(m_reg) * AW'(SYS_ARR_ROWS) + AW'(cnt_reg);
  assign head_acc  = (k_reg != '0);

  // Column gi is column gi-1 delayed one cycle; the chain never stalls, so bubbles travel diagonally.
  for (genvar gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
    logic          en_src, acc_src;
    logic [AW-1:0] addr_src;
    logic          en_reg, acc_reg;
    logic [AW-1:0] addr_reg;

    if (gi == 0) begin : g_head
      assign en_src   = issue_reg;
      assign acc_src  = head_acc;
      assign addr_src = head_addr;
    end else begin : g_tail
      assign en_src   = g_col[gi-1].en_reg;
      assign acc_src  = g_col[gi-1].acc_reg;
      assign addr_src = g_col[gi-1].addr_reg;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        en_reg   <= 1'b0;
        acc_reg  <= 1'b0;
        addr_reg <= '0;
      end else begin
        en_reg   <= en_src;
        acc_reg  <= acc_src;
        addr_reg <= addr_src;
      end
    end

    assign wr_en[gi]              = en_reg;
    assign wr_acc[gi]             = acc_reg;
    assign wr_addr[gi*AW +: AW]   = addr_reg;
  end

`ifdef ACCUM_SEQ_PERF_EN
  logic [31:0] perf_cycles_reg, perf_stalls_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_reg <= '0;
      perf_stalls_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      perf_cycles_reg <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (busy_reg && perf_cycles_reg != '1) begin
        perf_cycles_reg <= perf_cycles_reg + 1'b1;
      end
      if (state_reg == RUN && stall && perf_stalls_reg != '1) begin
        perf_stalls_reg <= perf_stalls_reg + 1'b1;
      end
    end
  end

  assign perf_cycles = perf_cycles_reg;
  assign perf_stalls = perf_stalls_reg;
`endif

endmodule

// File: doc/accum_tile_sequencer.md
# accum_tile_sequencer

Tile scheduler for the systolic-array output path. Given a matrix job of M×N output tiles with K reduction tiles, it walks tile coordinates and row counts, and drives `sys_arr_count`, `submat_m` and `submat_n` to the array. It also generates the column-skewed write enables, addresses and overwrite/accumulate mode for the accumulator table. It sits between the top-level command decoder and the accumulator table write ports.

## Interface
- `SYS_ARR_ROWS`, 16, systolic array rows (rows issued per tile)
- `SYS_ARR_COLS`, 16, systolic array columns (accumulator write lanes)
- `MAX_OUT_ROWS`, 128, max output matrix rows
- `MAX_OUT_COLS`, 128, max output matrix columns
- `MAX_K_TILES`, 8, max reduction tiles per job
- Derived:
  - NUM_SUBMATS_M = MAX_OUT_ROWS/SYS_ARR_ROWS
  - NUM_SUBMATS_N = MAX_OUT_COLS/SYS_ARR_COLS
  - NUM_ACCUM_ROWS = MAX_OUT_ROWS*NUM_SUBMATS_N
  - AW = $clog2(NUM_ACCUM_ROWS)

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `start` in 1: job request; sampled only in IDLE
- `num_m_m1` in $clog2(NUM_SUBMATS_M): tile rows minus 1
- `num_n_m1` in $clog2(NUM_SUBMATS_N): tile cols minus 1
- `num_k_m1` in $clog2(MAX_K_TILES): reduction tiles minus 1
- `stall` in 1: downstream backpressure, holds issue
- `busy` out 1: job in progress
- `done` out 1: one-cycle completion pulse
- `issue_valid` out 1: row issued to array this cycle
- `sys_arr_count` out $clog2(SYS_ARR_ROWS): row within tile
- `submat_m` out $clog2(NUM_SUBMATS_M): current tile row
- `submat_n` out $clog2(NUM_SUBMATS_N): current tile col
- `wr_en` out SYS_ARR_COLS: per-column accumulator write enable
- `wr_acc` out SYS_ARR_COLS: per column; 1 = accumulate, 0 = overwrite
- `wr_addr` out AW*SYS_ARR_COLS: per-column address; column c occupies bits [c*AW +: AW]

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`; the three size inputs are latched at that edge.
  - RUN→DRAIN after the final issue.
  - DRAIN→IDLE after SYS_ARR_COLS cycles.
- Loop order, innermost first: `sys_arr_count` (0..SYS_ARR_ROWS-1), then k (0..num_k_m1), then `submat_m`, then `submat_n`. All counters wrap to 0 when the next-outer counter advances.
- One row is issued per RUN cycle with `stall` low at the previous edge. With `stall` high, all counters hold and `issue_valid`=0.
- Column-0 write data, registered one cycle after the issue:
  - enable = issue_valid
  - address = submat_n*MAX_OUT_ROWS + submat_m*SYS_ARR_ROWS + sys_arr_count, computed at full AW width with no truncation
  - mode: `wr_acc` = (k != 0)
- Skew chain: column c carries the column-0 enable/address/mode delayed by c cycles. The chain shifts every cycle regardless of `stall`, so a stall produces a bubble with `wr_en`=0 that propagates diagonally.
- `start` during RUN/DRAIN is ignored.
- Reset values:
  - all outputs 0 (`busy`, `done`, `issue_valid`, counters, `wr_en`, `wr_acc`, `wr_addr`)
  - FSM in IDLE
  - skew chain cleared
- Reset mid-job aborts the job: `wr_en` is 0 from the first cycle after the reset edge, and `done` is not pulsed.

## Timing
- With `start` sampled at edge T:
  - `busy`=1 and first `issue_valid`=1 in the cycle after T, with `sys_arr_count`=0 and all tile coordinates 0.
  - L = (num_m_m1+1)*(num_n_m1+1)*(num_k_m1+1)*SYS_ARR_ROWS, plus the number of stalled cycles.
  - Issues occupy cycles T+1..T+L.
  - `wr_en[c]` for the row issued in cycle t is high in cycle t+1+c.
  - Last write appears on column SYS_ARR_COLS-1 in cycle T+L+SYS_ARR_COLS.
  - `done`=1 and `busy`=0 in cycle T+L+SYS_ARR_COLS+1.
- A new `start` is accepted in the `done` cycle; back-to-back jobs are allowed.
- `stall` asserted during DRAIN has no effect.

## Configuration
- `ACCUM_SEQ_PERF_EN`
  - Defined: adds outputs `perf_cycles` (32 bits) and `perf_stalls` (32 bits).
    - Both clear on accepted `start`.
    - `perf_cycles` increments every cycle while `busy`=1.
    - `perf_stalls` increments every RUN cycle with `stall`=1.
    - Both counters saturate at all ones and hold their value after `done`.
    - Both reset to 0.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- 1×1×1 job (all `*_m1`=0), default params, `start` at T:
  - `issue_valid` high T+1..T+16.
  - `wr_en[0]` high T+2..T+17 with addresses 0..15 and `wr_acc`=0.
  - `wr_en[15]` high T+17..T+32.
  - `done` at T+33.
- K=2 (`num_k_m1`=1), M=N=1:
  - Rows 0..15 are written twice to addresses 0..15.
  - `wr_acc`=0 on the first pass, 1 on the second.
  - `done` at T+49.
- `num_m_m1`=1, `num_n_m1`=1, K=1:
  - Issue order is (m,n) = (0,0), (1,0), (0,1), (1,1).
  - Base addresses 0, 16, 128, 144.
  - `done` at T+81.
- 1×1×1 job with `stall` high for 3 cycles mid-tile:
  - Counters hold.
  - A 3-cycle `wr_en` bubble appears on column 0 and reaches column 15 fifteen cycles later.
  - `done` at T+36.
  - With `ACCUM_SEQ_PERF_EN` defined: `perf_stalls`=3 and `perf_cycles`=35.
- `reset` asserted 10 cycles into a job:
  - All outputs 0 the next cycle, no `done` pulse.
  - A new `start` runs normally.
- `start` held high through the `done` cycle: a second job begins on the cycle after `done`. A `start` pulsed during RUN is ignored.
